// File: rtl/uart_rx_wb_ctrl.sv
// UART receive FIFO with a Wishbone classic slave register port.
// Registers: DATA, STATUS, CTRL, COUNT; level irq on data or overrun.
module uart_rx_wb_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_busy,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_ACK  = 1'b1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_COUNT  = 2'd3;

  logic          state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          rx_enable;
  logic          irq_en;

  logic       req;
  logic       rd_req;
  logic       wr_req;
  logic       not_empty;
  logic       full;
  logic       pop;
  logic       flush;
  logic       push_req;
  logic       push;
  logic       ovr_set;
  logic       ovr_clr;
  logic [7:0] rd_mux;

  // Decode the accepted access and the FIFO push/pop/flush strobes
  always_comb begin
    req       = wb_cyc_i & wb_stb_i & (state == S_IDLE);
    rd_req    = req & ~wb_we_i;
    wr_req    = req & wb_we_i;
    not_empty = (count != '0);
    full      = (count == CW'(FIFO_DEPTH));
    pop       = rd_req & (wb_adr_i == A_DATA) & not_empty;
    flush     = wr_req & (wb_adr_i == A_CTRL) & wb_dat_i[2];
    push_req  = rx_done & rx_enable & ~flush;
    push      = push_req & (~full | pop);
    ovr_set   = push_req & full & ~pop;
    ovr_clr   = wr_req & (wb_adr_i == A_STATUS) & wb_dat_i[2];
  end

  // Select the register image returned on a read
  always_comb begin
    rd_mux = 8'h00;
    unique case (wb_adr_i)
      A_DATA:   rd_mux = not_empty ? mem[rd_ptr] : 8'h00;
      A_STATUS: rd_mux = {4'b0, rx_busy, overrun, full, not_empty};
      A_CTRL:   rd_mux = {6'b0, irq_en, rx_enable};
      A_COUNT:  rd_mux = 8'(count);
    endcase
  end

  // Bus FSM: one-cycle ack after each sampled request, read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      unique case (state)
        S_IDLE: begin
          wb_ack_o <= req;
          if (req) begin
            state    <= S_ACK;
            wb_dat_o <= wb_we_i ? 8'h00 : rd_mux;
          end
        end
        S_ACK: begin
          state    <= S_IDLE;
          wb_ack_o <= 1'b0;
        end
      endcase
    end
  end

  // Control bits and sticky overrun (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_enable <= 1'b0;
      irq_en    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_req && wb_adr_i == A_CTRL) begin
        rx_enable <= wb_dat_i[0];
        irq_en    <= wb_dat_i[1];
      end
      if (ovr_set)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; full/empty come from count only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rx_data;
  end

  // Registered level interrupt from current FIFO/overrun state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= irq_en & (not_empty | overrun);
  end

endmodule

// File: tb/tb_uart_rx_wb_ctrl.sv
// Directed bench for uart_rx_wb_ctrl (depth 16).
// Hand-computed expectations for each register access.
module tb_uart_rx_wb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic [1:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_wb_ctrl #(.FIFO_DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus access; optional rx_done strobe on the same request edge
  task automatic wb_xfer(input logic we,
                         input logic [1:0] adr,
                         input logic [7:0] dat,
                         input logic with_rx,
                         input logic [7:0] rxb,
                         output logic [7:0] rd);
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    if (with_rx) begin
      rx_data = rxb;
      rx_done = 1'b1;
    end
    @(posedge clk);
    #1;
    check("ack", wb_ack_o, 1'b1);
    rd       = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    rx_done  = 1'b0;
    @(posedge clk);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
    logic [7:0] unused;
    wb_xfer(1'b1, adr, dat, 1'b0, 8'h00, unused);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [1:0] adr,
                        input logic [7:0] exp);
    logic [7:0] d;
    wb_xfer(1'b0, adr, 8'h00, 1'b0, 8'h00, d);
    check(tag, d, exp);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rx_busy = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
    wb_adr_i = 2'd0;
    wb_dat_i = 8'h00;
    #1;
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_dat", wb_dat_o, 8'h00);
    check("rst_irq", irq, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    rd_chk("rst_count", 2'd3, 8'h00);
    rd_chk("rst_ctrl", 2'd2, 8'h00);
    push(8'h99);
    rd_chk("disabled_count", 2'd3, 8'h00);
    rd_chk("disabled_status", 2'd1, 8'h00);

    // Basic receive path with interrupt
    wr(2'd2, 8'h03);
    push(8'h41);
    push(8'h42);
    rd_chk("b_count", 2'd3, 8'h02);
    rd_chk("b_status", 2'd1, 8'h01);
    #1;
    check("b_irq_on", irq, 1'b1);
    rd_chk("b_rd0", 2'd0, 8'h41);
    rd_chk("b_rd1", 2'd0, 8'h42);
    #1;
    check("b_irq_off", irq, 1'b0);
    rd_chk("b_count0", 2'd3, 8'h00);
    rd_chk("b_empty_rd", 2'd0, 8'h00);

    // Status reflects rx_busy; cyc without stb does nothing
    rx_busy = 1'b1;
    rd_chk("busy_status", 2'd1, 8'h08);
    rx_busy = 1'b0;
    push(8'h77);
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    check("nostb_ack", wb_ack_o, 1'b0);
    wb_cyc_i = 1'b0;
    rd_chk("nostb_count", 2'd3, 8'h01);
    rd_chk("nostb_rd", 2'd0, 8'h77);

    // Overflow: 17 pushes into 16 slots
    wr(2'd2, 8'h01);
    for (int i = 0; i < 17; i++) push(8'(i));
    rd_chk("ov_count", 2'd3, 8'h10);
    rd_chk("ov_status", 2'd1, 8'h07);
    for (int i = 0; i < 16; i++) rd_chk("ov_rd", 2'd0, 8'(i));
    rd_chk("ov_status2", 2'd1, 8'h04);
    wr(2'd1, 8'h04);
    rd_chk("ov_w1c", 2'd1, 8'h00);

    // Full FIFO, push coincident with pop
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    wb_xfer(1'b0, 2'd0, 8'h00, 1'b1, 8'hAA, d);
    check("fp_rd", d, 8'h20);
    rd_chk("fp_count", 2'd3, 8'h10);
    rd_chk("fp_status", 2'd1, 8'h03);
    for (int i = 1; i < 16; i++) rd_chk("fp_rd_n", 2'd0, 8'(8'h20 + i));
    rd_chk("fp_last", 2'd0, 8'hAA);
    rd_chk("fp_count0", 2'd3, 8'h00);

    // Empty FIFO, push coincident with read
    wb_xfer(1'b0, 2'd0, 8'h00, 1'b1, 8'h5A, d);
    check("ep_rd", d, 8'h00);
    rd_chk("ep_count", 2'd3, 8'h01);
    rd_chk("ep_rd2", 2'd0, 8'h5A);

    // Flush with coincident push
    wr(2'd2, 8'h03);
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    wb_xfer(1'b1, 2'd2, 8'h07, 1'b1, 8'hEE, d);
    rd_chk("fl_count", 2'd3, 8'h00);
    rd_chk("fl_ctrl", 2'd2, 8'h03);
    rd_chk("fl_status", 2'd1, 8'h00);
    rd_chk("fl_rd", 2'd0, 8'h00);

    // Reset during an ack cycle
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = 2'd3;
    @(posedge clk);
    #1;
    check("mr_ack_pre", wb_ack_o, 1'b1);
    check("mr_irq_pre", irq, 1'b1);
    rst = 1'b1;
    #1;
    check("mr_ack", wb_ack_o, 1'b0);
    check("mr_irq", irq, 1'b0);
    check("mr_dat", wb_dat_o, 8'h00);
    @(negedge clk);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    rst = 1'b0;
    rd_chk("mr_count", 2'd3, 8'h00);
    rd_chk("mr_ctrl", 2'd2, 8'h00);
    push(8'h11);
    rd_chk("mr_ignored", 2'd3, 8'h00);
    wr(2'd2, 8'h01);
    push(8'h12);
    rd_chk("mr_count1", 2'd3, 8'h01);
    rd_chk("mr_rd", 2'd0, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_wb_ctrl.md
UART_RX_WB_CTRL -- requirements
Module: uart_rx_wb_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, receive FIFO depth in bytes; power of two, 2..128.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_data  input  8  received byte from UART receiver, valid when rx_done=1.
REQ-005 rx_done  input  1  one-cycle strobe: rx_data holds a complete byte.
REQ-006 rx_busy  input  1  receiver currently mid-frame, status only.
REQ-007 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic slave cycle, strobe, write-enable.
REQ-008 wb_adr_i  input  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 COUNT.
REQ-009 wb_dat_i  input  8  write data.
REQ-010 wb_dat_o  output  8  read data, valid while wb_ack_o=1.
REQ-011 wb_ack_o  output  1  transfer acknowledge.
REQ-012 irq  output  1  level interrupt request.

Function
REQ-013 Bus FSM SHALL have two states: IDLE, ACK; IDLE->ACK on wb_cyc_i&wb_stb_i sampled 1; ACK->IDLE unconditionally.
REQ-014 wb_ack_o SHALL be 1 only in ACK, i.e. exactly one cycle after request sampled; never two consecutive cycles.
REQ-015 All register side effects and wb_dat_o capture SHALL occur on the IDLE->ACK edge; each access acts once.
REQ-016 DATA read: wb_dat_o = FIFO head, one pop; if FIFO empty, wb_dat_o = 0x00, no pop, no error. DATA write: ignored.
REQ-017 STATUS read: bit0 not_empty, bit1 full, bit2 overrun, bit3 rx_busy, bits 7:4 = 0.
REQ-018 STATUS write: wb_dat_i bit2 = 1 clears overrun (W1C); other bits ignored.
REQ-019 CTRL: bit0 rx_enable RW, bit1 irq_en RW, bit2 flush write-1 self-clearing (reads 0), bits 7:3 read 0.
REQ-020 COUNT read: FIFO occupancy 0..FIFO_DEPTH, zero-extended to 8 bits; writes ignored.
REQ-021 Push: rx_done=1 and rx_enable=1; rx_done with rx_enable=0 SHALL be discarded silently (no overrun).
REQ-022 Push when full and no pop same cycle: byte dropped, FIFO contents unchanged, overrun set to 1.
REQ-023 Push and pop same cycle: both performed; if full, slot freed by pop accepts byte, no overrun; count unchanged.
REQ-024 Push and DATA-read same cycle on empty FIFO: read returns 0x00, byte stored, count becomes 1.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty distinguished via count, never by pointer equality alone.
REQ-026 Flush: count and pointers to 0 on the write edge; a push in the same cycle SHALL be discarded; overrun unchanged.
REQ-027 Overrun set and W1C clear same cycle: set wins (overrun=1).
REQ-028 irq SHALL be registered: irq <= irq_en & (not_empty | overrun), one cycle after the causing state change.
REQ-029 Accesses with wb_cyc_i=0 or wb_stb_i=0 SHALL have no effect.

Reset
REQ-030 On rst=1, immediately: FSM IDLE, wb_ack_o=0, wb_dat_o=0x00, irq=0, count=0, pointers=0, overrun=0, rx_enable=0, irq_en=0.
REQ-031 Reset mid-transfer SHALL abort the ack; FIFO contents are discarded; the bus master re-issues.
REQ-032 After rst deasserts, first request SHALL be acked on the cycle after it is sampled.

Verification
REQ-033 Write CTRL=0x03; strobe rx_done with 0x41, 0x42 -> COUNT=2, STATUS=0x01, irq=1; two DATA reads return 0x41, 0x42; COUNT=0, irq=0 one cycle later.
REQ-034 rx_enable=1, push 17 bytes 0x00..0x10 with depth 16 -> COUNT=16, STATUS bit1=1, bit2=1; reads return 0x00..0x0F; write STATUS=0x04 -> overrun=0.
REQ-035 Full FIFO, rx_done coincident with DATA-read ack edge -> read returns oldest byte, COUNT stays 16, overrun stays 0, new byte read last.
REQ-036 Empty FIFO, DATA read coincident with rx_done 0x5A -> wb_dat_o=0x00, next DATA read returns 0x5A.
REQ-037 Push 5 bytes, write CTRL=0x07 with rx_done same cycle -> COUNT=0, CTRL reads 0x03, overrun=0, DATA read returns 0x00.
REQ-038 Push 3 bytes, assert rst during an ack cycle -> wb_ack_o=0 immediately, COUNT=0, CTRL=0x00, irq=0; rx_done ignored until CTRL bit0 rewritten.
